// File: rtl/pwm_pkg.sv
// pwm_pkg: register offsets, STATUS bit positions and capture FSM states shared by the PWM blocks.
package pwm_pkg;
  localparam logic [2:0] ADDR_PERIOD = 3'd0;
  localparam logic [2:0] ADDR_HIGH = 3'd2;
  localparam logic [2:0] ADDR_CTRL = 3'd4;
  localparam int ST_ENABLE = 0;
  localparam int ST_VALID = 1;
  localparam int ST_OVF = 2;
  localparam int ST_PWM = 3;
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} cap_state_t;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: 16-bit I/O bus window with chip select; the CPU side is master.
interface pwm_capture_if;
  logic cap_ctrl;
  logic write_enable;
  logic read_enable;
  logic [2:0] address;
  logic [15:0] write_data_in;
  logic [15:0] read_data_out;
  modport master(output cap_ctrl, write_enable, read_enable, address, write_data_in, input read_data_out);
  modport slave(input cap_ctrl, write_enable, read_enable, address, write_data_in, output read_data_out);
endinterface

// File: rtl/pwm_sync_edge.sv
// pwm_sync_edge: multi-flop synchronizer for an async input plus rising-edge detect on the synced level.
module pwm_sync_edge #(
  parameter int STAGES = 2
) (
  input logic clock,
  input logic reset,
  input logic async_in,
  output logic level,
  output logic rise
);
  logic [STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clock) begin
    if (reset) begin
      chain <= '0;
      prev <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev <= chain[STAGES-1];
    end
  end
  assign level = chain[STAGES-1];
  assign rise = level & ~prev;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of pwm_in, exposed as PERIOD/HIGH/CTRL-STATUS registers.
// Define PWM_CAPTURE_IRQ_EN for an irq output (capture or new overflow) maskable by CTRL bit2.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic clock,
  input logic reset,
  input logic pwm_in,
  pwm_capture_if.slave bus
`ifdef PWM_CAPTURE_IRQ_EN
  ,
  output logic irq
`endif
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  cap_state_t state, next_state;
  logic pwm_s, rise, enable, valid, ovf;
  logic ctrl_wr, status_rd, start, capture, overflow, counting;
  logic [CNT_WIDTH-1:0] period_cnt, high_cnt, period_reg, high_reg, period_nxt, high_nxt;
  logic [15:0] status;

  pwm_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clock(clock),
    .reset(reset),
    .async_in(pwm_in),
    .level(pwm_s),
    .rise(rise)
  );

  assign ctrl_wr = bus.cap_ctrl & bus.write_enable & (bus.address == ADDR_CTRL);
  assign status_rd = bus.cap_ctrl & bus.read_enable & (bus.address == ADDR_CTRL);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end

  always_comb begin
    next_state = !enable ? IDLE :
                 state == IDLE ? ARM :
                 state == ARM ? (rise ? MEASURE : ARM) :
                 overflow ? ARM : MEASURE;
  end

  always_comb begin
    start = enable && state == ARM && rise;
    capture = enable && state == MEASURE && rise;
    overflow = enable && state == MEASURE && !rise && period_cnt == CNT_MAX;
    counting = enable && state == MEASURE && !rise && !overflow;
    period_nxt = (start || capture) ? CNT_WIDTH'(1) : counting ? period_cnt + 1'b1 : '0;
    high_nxt = (start || capture) ? CNT_WIDTH'(1) : counting ? high_cnt + CNT_WIDTH'(pwm_s) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period_cnt <= '0;
      high_cnt <= '0;
      period_reg <= '0;
      high_reg <= '0;
      enable <= 1'b0;
      valid <= 1'b0;
      ovf <= 1'b0;
    end else begin
      period_cnt <= period_nxt;
      high_cnt <= high_nxt;
      if (capture) begin
        period_reg <= period_cnt;
        high_reg <= high_cnt;
      end
      enable <= ctrl_wr ? bus.write_data_in[0] : enable;
      // a capture in the same cycle as a STATUS read keeps valid set
      valid <= !enable ? 1'b0 : capture ? 1'b1 : status_rd ? 1'b0 : valid;
      ovf <= overflow | (ovf & ~(ctrl_wr & bus.write_data_in[1]));
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic irq_mask;
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_mask <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq_mask <= ctrl_wr ? bus.write_data_in[2] : irq_mask;
      irq <= (capture | (overflow & ~ovf)) & ~irq_mask;
    end
  end
`endif

  always_comb begin
    status = '0;
    status[ST_ENABLE] = enable;
    status[ST_VALID] = valid;
    status[ST_OVF] = ovf;
    status[ST_PWM] = pwm_s;
    bus.read_data_out = !(bus.cap_ctrl && bus.read_enable) ? '0 :
                        bus.address == ADDR_PERIOD ? 16'(period_reg) :
                        bus.address == ADDR_HIGH ? 16'(high_reg) :
                        bus.address == ADDR_CTRL ? status : '0;
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: table vectors, random waveforms against a history-based period model, and corner sequences.
module tb_pwm_capture;
  import pwm_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pwm_in = 1'b0;
  int checks = 0;
  int errors = 0;
  bit hist[$];
  pwm_capture_if bus ();
`ifdef PWM_CAPTURE_IRQ_EN
  logic irq;
`endif

  pwm_capture dut (
    .clock(clock),
    .reset(reset),
    .pwm_in(pwm_in),
    .bus(bus)
`ifdef PWM_CAPTURE_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    int h;
    int l;
    int period;
    int high;
  } vec_t;

  task automatic idle_bus();
    bus.cap_ctrl = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    bus.address = 3'd0;
    bus.write_data_in = 16'd0;
  endtask

  task automatic tick();
    hist.push_back(pwm_in);
    @(posedge clock);
    #1;
    idle_bus();
  endtask

  task automatic drive(bit lvl, int n);
    pwm_in = lvl;
    repeat (n) tick();
  endtask

  task automatic wr(logic [2:0] a, logic [15:0] d);
    bus.cap_ctrl = 1'b1;
    bus.write_enable = 1'b1;
    bus.address = a;
    bus.write_data_in = d;
    tick();
  endtask

  // the strobe stays asserted until the next tick so STATUS reads take effect at that edge
  task automatic rd(logic [2:0] a, output logic [15:0] d);
    bus.cap_ctrl = 1'b1;
    bus.read_enable = 1'b1;
    bus.address = a;
    #1;
    d = bus.read_data_out;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic rd_chk(string name, logic [2:0] a, logic [15:0] exp);
    logic [15:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  // last complete period of the input history: distance between the two latest rises, ones counted between
  function automatic void model(output int per, output int hi);
    int r1 = -1, r2 = -1;
    for (int i = hist.size() - 1; i > 0; i--)
      if (hist[i] && !hist[i-1]) begin
        if (r2 < 0) r2 = i;
        else begin
          r1 = i;
          break;
        end
      end
    per = (r1 < 0) ? 0 : r2 - r1;
    hi = 0;
    if (r1 >= 0) for (int i = r1; i < r2; i++) hi += int'(hist[i]);
  endfunction

  task automatic run_wave(int h, int l, int n);
    drive(1'b0, 5);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
    drive(1'b1, 6);
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] s;
    int per, hi, t_cap, cnt, pulses, dbl;
    bit prev;
    vecs[0] = '{3, 5, 8, 3};
    vecs[1] = '{50, 50, 100, 50};
    vecs[2] = '{1, 1, 2, 1};
    vecs[3] = '{1, 7, 8, 1};
    vecs[4] = '{7, 1, 8, 7};
    vecs[5] = '{2, 2, 4, 2};
    idle_bus();
    repeat (3) tick();
    reset = 1'b0;
    rd_chk("reset_period", ADDR_PERIOD, 16'h0);
    rd_chk("reset_high", ADDR_HIGH, 16'h0);
    rd_chk("reset_status", ADDR_CTRL, 16'h0);
`ifdef PWM_CAPTURE_IRQ_EN
    chk("reset_irq", irq, 1'b0);
`endif
    tick();
    wr(ADDR_PERIOD, 16'hFFFF);
    wr(ADDR_HIGH, 16'hFFFF);
    rd_chk("ignored_wr_period", ADDR_PERIOD, 16'h0);
    rd_chk("ignored_wr_status", ADDR_CTRL, 16'h0);
    tick();
    wr(ADDR_CTRL, 16'h0001);
    rd_chk("enable_status", ADDR_CTRL, 16'h0001);

    foreach (vecs[i]) begin
      run_wave(vecs[i].h, vecs[i].l, 2);
      rd_chk($sformatf("vec%0d_period", i), ADDR_PERIOD, 16'(vecs[i].period));
      rd_chk($sformatf("vec%0d_high", i), ADDR_HIGH, 16'(vecs[i].high));
      rd_chk($sformatf("vec%0d_status", i), ADDR_CTRL, 16'h000B);
      tick();
      rd_chk($sformatf("vec%0d_status_rtc", i), ADDR_CTRL, 16'h0009);
      tick();
    end

    for (int t = 0; t < 8; t++) begin
      run_wave($urandom_range(1, 60), $urandom_range(1, 60), $urandom_range(1, 3));
      model(per, hi);
      if (t == 0) begin
        bus.cap_ctrl = 1'b0;
        bus.read_enable = 1'b1;
        bus.address = ADDR_PERIOD;
        #1;
        chk("unselected_read", bus.read_data_out, 16'h0);
        rd_chk("addr6_read", 3'd6, 16'h0);
      end
      rd_chk($sformatf("rand%0d_period", t), ADDR_PERIOD, 16'(per));
      rd_chk($sformatf("rand%0d_high", t), ADDR_HIGH, 16'(hi));
      rd_chk($sformatf("rand%0d_status", t), ADDR_CTRL, 16'h000B);
      tick();
      tick();
    end

    // stalled waveform: one rise, then low until the counter saturates
    drive(1'b0, 10);
    pwm_in = 1'b1;
    tick();
    pwm_in = 1'b0;
    t_cap = -1;
    for (int k = 0; k < 20; k++) begin
      rd(ADDR_CTRL, s);
      if (s[ST_VALID]) begin
        t_cap = k;
        break;
      end
      tick();
    end
    chk("ovf_capture_seen", t_cap >= 0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 70000; k++) begin
      rd(ADDR_CTRL, s);
      if (s[ST_OVF]) break;
      tick();
      cnt++;
    end
    chk("ovf_cycles_after_capture", cnt, 65535);
    model(per, hi);
    rd_chk("ovf_period_kept", ADDR_PERIOD, 16'(per));
    rd_chk("ovf_high_kept", ADDR_HIGH, 16'(hi));
    rd_chk("ovf_status", ADDR_CTRL, 16'h0005);
    tick();
    wr(ADDR_CTRL, 16'h0003);
    rd_chk("ovf_cleared", ADDR_CTRL, 16'h0001);
    tick();

    // disable mid-measurement, then re-enable needs two fresh rises
    repeat (2) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    drive(1'b1, 2);
    drive(1'b0, 3);
    wr(ADDR_CTRL, 16'h0000);
    tick();
    rd(ADDR_CTRL, s);
    chk("disable_status", (s == 16'h0000) || (s == 16'h0008), 1'b1);
    rd_chk("disable_period", ADDR_PERIOD, 16'd8);
    rd_chk("disable_high", ADDR_HIGH, 16'd4);
    tick();
    wr(ADDR_CTRL, 16'h0001);
    drive(1'b1, 5);
    drive(1'b0, 2);
    rd(ADDR_CTRL, s);
    chk("reenable_one_rise_valid", s[ST_VALID], 1'b0);
    rd_chk("reenable_one_rise_period", ADDR_PERIOD, 16'd8);
    drive(1'b1, 5);
    rd_chk("reenable_period", ADDR_PERIOD, 16'd7);
    rd_chk("reenable_high", ADDR_HIGH, 16'd5);
    rd(ADDR_CTRL, s);
    chk("reenable_valid", s[ST_VALID], 1'b1);
    tick();

    // reset in the middle of a 4/4 measurement
    drive(1'b0, 4);
    drive(1'b1, 2);
    reset = 1'b1;
    pwm_in = 1'b0;
    tick();
    reset = 1'b0;
    rd_chk("midreset_period", ADDR_PERIOD, 16'h0);
    rd_chk("midreset_high", ADDR_HIGH, 16'h0);
    rd_chk("midreset_status", ADDR_CTRL, 16'h0);
    tick();
    repeat (3) begin
      drive(1'b1, 4);
      drive(1'b0, 4);
    end
    rd_chk("postreset_period", ADDR_PERIOD, 16'h0);
    rd_chk("postreset_status", ADDR_CTRL, 16'h0);
    tick();

`ifdef PWM_CAPTURE_IRQ_EN
    wr(ADDR_CTRL, 16'h0001);
    repeat (3) begin
      drive(1'b1, 2);
      drive(1'b0, 2);
    end
    pulses = 0;
    dbl = 0;
    prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pwm_in = (k % 4) < 2;
      tick();
      if (irq) pulses++;
      if (irq && prev) dbl++;
      prev = irq;
    end
    chk("irq_pulses", pulses, 10);
    chk("irq_single_cycle", dbl, 0);
    wr(ADDR_CTRL, 16'h0005);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      pwm_in = (k % 4) < 2;
      tick();
      if (irq) pulses++;
    end
    chk("irq_masked", pulses, 0);
    rd(ADDR_CTRL, s);
    chk("irq_masked_valid", s[ST_VALID], 1'b1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
